urv_decode_mc: RTL and testbench



---
 rtl/urv_decode_mc_pkg.sv | 56 +++++
 rtl/urv_decode_hazard.sv | 90 +++++++++
 rtl/urv_decode_mc.sv | 169 ++++++++++++++++
 tb/tb_urv_decode_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_decode_mc_pkg.sv
// uRV decode shared definitions: opcodes, ALU functions, branch codes,
// rd sources, bubble FSM states and the immediate decoder.
package urv_decode_mc_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [2:0] FUNC_ADD  = 3'b000;
    localparam logic [2:0] FUNC_SL   = 3'b001;
    localparam logic [2:0] FUNC_SLT  = 3'b010;
    localparam logic [2:0] FUNC_SLTU = 3'b011;
    localparam logic [2:0] FUNC_XOR  = 3'b100;
    localparam logic [2:0] FUNC_SR   = 3'b101;
    localparam logic [2:0] FUNC_OR   = 3'b110;
    localparam logic [2:0] FUNC_AND  = 3'b111;

    localparam logic [2:0] BRA_EQ  = 3'b000;
    localparam logic [2:0] BRA_NEQ = 3'b001;
    localparam logic [2:0] BRA_LT  = 3'b100;
    localparam logic [2:0] BRA_GE  = 3'b101;
    localparam logic [2:0] BRA_LTU = 3'b110;
    localparam logic [2:0] BRA_GEU = 3'b111;

    localparam logic [2:0] RD_SOURCE_ALU      = 3'd0;
    localparam logic [2:0] RD_SOURCE_SHIFTER  = 3'd1;
    localparam logic [2:0] RD_SOURCE_MULTIPLY = 3'd2;
    localparam logic [2:0] RD_SOURCE_DIVIDE   = 3'd3;
    localparam logic [2:0] RD_SOURCE_CSR      = 3'd4;

    typedef enum logic {
        ST_IDLE,
        ST_BUBBLE
    } bub_state_t;

    function automatic logic [31:0] imm_decode(input logic [31:0] ir);
        logic [31:0] imm;
        unique case (ir[6:2])
            OPC_LUI, OPC_AUIPC: imm = {ir[31:12], 12'h000};
            OPC_JAL:    imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            OPC_BRANCH: imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_STORE:  imm = {{21{ir[31]}}, ir[30:25], ir[11:7]};
            default:    imm = {{21{ir[31]}}, ir[30:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/urv_decode_hazard.sv
// Operand-use decode, load/mul-use hazard detection and the
// multi-cycle bubble sequencer of the uRV decode stage.
module urv_decode_hazard
    import urv_decode_mc_pkg::*;
#(
    parameter int unsigned g_load_bubbles = 1,
    parameter int unsigned g_mul_bubbles  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_stall,
    input  logic       d_kill,
    input  logic [4:0] opc,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       f_valid,
    input  logic       x_valid,
    input  logic [4:0] x_rd,
    input  logic       x_load,
    input  logic       x_mulshift,
    output logic       stall_req,
    output logic       bubble
);

    localparam logic [1:0] LOAD_N = 2'(g_load_bubbles);
    localparam logic [1:0] MUL_N  = 2'(g_mul_bubbles);

    bub_state_t state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       use_rs1, use_rs2;
    logic       rs_match, hz_base, load_hz, mul_hz;
    logic [1:0] n_sel;

    always_comb begin
        use_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
        use_rs2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
    end

    assign rs_match = (use_rs1 && rs1 == x_rd) || (use_rs2 && rs2 == x_rd);
    assign hz_base  = x_valid && f_valid && !d_kill
                   && x_rd != 5'd0 && rs_match;
    assign load_hz  = hz_base && x_load;
    assign mul_hz   = hz_base && x_mulshift;
    assign n_sel    = load_hz ? LOAD_N : MUL_N;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Kill and reset abort a sequence and release the stall at once.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_req = 1'b0;
        bubble    = 1'b0;
        if (rst || d_kill) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 2'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (load_hz || mul_hz) begin
                        stall_req = 1'b1;
                        bubble    = 1'b1;
                        if (!d_stall && n_sel > 2'd1) begin
                            state_nxt = ST_BUBBLE;
                            cnt_nxt   = n_sel - 2'd1;
                        end
                    end
                end
                ST_BUBBLE: begin
                    stall_req = 1'b1;
                    bubble    = 1'b1;
                    if (!d_stall) begin
                        cnt_nxt = cnt - 2'd1;
                        if (cnt == 2'd1) state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/urv_decode_mc.sv
// uRV decode stage: register-file read addresses, instruction decode
// and registered X-stage controls with hazard bubble insertion.
module urv_decode_mc
    import urv_decode_mc_pkg::*;
#(
    parameter int unsigned g_load_bubbles = 1,
    parameter int unsigned g_mul_bubbles  = 1,
    parameter bit          g_with_hw_mulh = 1'b0,
    parameter bit          g_with_hw_div  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_stall_i,
    input  logic        d_kill_i,
    output logic        d_stall_req_o,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        x_valid_o,
    output logic [31:0] x_pc_o,
    output logic [4:0]  x_rs1_o,
    output logic [4:0]  x_rs2_o,
    output logic [4:0]  x_rd_o,
    output logic [4:0]  x_opcode_o,
    output logic [2:0]  x_fun_o,
    output logic [31:0] x_imm_o,
    output logic [2:0]  x_rd_source_o,
    output logic        x_rd_write_o,
    output logic        x_is_load_o,
    output logic        x_is_store_o,
    output logic        x_is_mul_o,
    output logic        x_is_div_o,
    output logic        x_is_illegal_o
);

    logic [4:0]  opc, rd;
    logic [2:0]  fun, d_fun, d_src;
    logic        is_m, d_wr_op, d_wr, d_load, d_store, d_mul, d_div, d_ill;
    logic [31:0] d_imm;
    logic        bubble, take, x_mulshift;

    assign opc      = f_ir_i[6:2];
    assign fun      = f_ir_i[14:12];
    assign rd       = f_ir_i[11:7];
    assign is_m     = f_ir_i[31:25] == 7'b0000001;
    assign rf_rs1_o = f_ir_i[19:15];
    assign rf_rs2_o = f_ir_i[24:20];

    always_comb begin
        d_fun   = fun;
        d_src   = RD_SOURCE_ALU;
        d_wr_op = 1'b0;
        d_load  = 1'b0;
        d_store = 1'b0;
        d_mul   = 1'b0;
        d_div   = 1'b0;
        d_ill   = 1'b0;
        d_imm   = imm_decode(f_ir_i);
        if (f_ir_i[1:0] != 2'b11) begin
            d_ill = 1'b1;
        end else begin
            unique case (opc)
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                    d_fun   = FUNC_ADD;
                    d_wr_op = 1'b1;
                end
                OPC_LOAD: begin
                    d_load  = 1'b1;
                    d_wr_op = 1'b1;
                end
                OPC_STORE: d_store = 1'b1;
                OPC_BRANCH, OPC_FENCE: ;
                OPC_OP_IMM: begin
                    d_wr_op = 1'b1;
                    if (fun == FUNC_SL || fun == FUNC_SR)
                        d_src = RD_SOURCE_SHIFTER;
                end
                OPC_OP: begin
                    d_wr_op = 1'b1;
                    if (is_m) begin
                        // Disabled M-ops stay on the ALU source, flagged illegal.
                        if (fun == 3'b000 || (!fun[2] && g_with_hw_mulh)) begin
                            d_mul = 1'b1;
                            d_src = RD_SOURCE_MULTIPLY;
                        end else if (fun[2] && g_with_hw_div) begin
                            d_div = 1'b1;
                            d_src = RD_SOURCE_DIVIDE;
                        end else begin
                            d_ill = 1'b1;
                        end
                    end else if (fun == FUNC_SL || fun == FUNC_SR) begin
                        d_src = RD_SOURCE_SHIFTER;
                    end
                end
                OPC_SYSTEM: begin
                    d_src   = RD_SOURCE_CSR;
                    d_wr_op = fun != 3'b000;
                end
                default: d_ill = 1'b1;
            endcase
        end
    end

    assign d_wr = d_wr_op && !d_ill && rd != 5'd0;

    assign x_mulshift = x_is_mul_o || x_rd_source_o == RD_SOURCE_SHIFTER;

    urv_decode_hazard #(
        .g_load_bubbles(g_load_bubbles),
        .g_mul_bubbles (g_mul_bubbles)
    ) u_hazard (
        .clk       (clk_i),
        .rst       (rst_i),
        .d_stall   (d_stall_i),
        .d_kill    (d_kill_i),
        .opc       (opc),
        .rs1       (f_ir_i[19:15]),
        .rs2       (f_ir_i[24:20]),
        .f_valid   (f_valid_i),
        .x_valid   (x_valid_o),
        .x_rd      (x_rd_o),
        .x_load    (x_is_load_o),
        .x_mulshift(x_mulshift),
        .stall_req (d_stall_req_o),
        .bubble    (bubble)
    );

    assign take = f_valid_i && !bubble;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_valid_o      <= 1'b0;
            x_pc_o         <= 32'd0;
            x_rd_write_o   <= 1'b0;
            x_is_load_o    <= 1'b0;
            x_is_store_o   <= 1'b0;
            x_is_mul_o     <= 1'b0;
            x_is_div_o     <= 1'b0;
            x_is_illegal_o <= 1'b0;
        end else if (d_kill_i) begin
            x_valid_o      <= 1'b0;
            x_rd_write_o   <= 1'b0;
            x_is_load_o    <= 1'b0;
            x_is_store_o   <= 1'b0;
            x_is_mul_o     <= 1'b0;
            x_is_div_o     <= 1'b0;
            x_is_illegal_o <= 1'b0;
        end else if (!d_stall_i) begin
            x_valid_o      <= take;
            x_pc_o         <= f_pc_i;
            x_rs1_o        <= f_ir_i[19:15];
            x_rs2_o        <= f_ir_i[24:20];
            x_rd_o         <= rd;
            x_opcode_o     <= opc;
            x_fun_o        <= d_fun;
            x_imm_o        <= d_imm;
            x_rd_source_o  <= d_src;
            x_rd_write_o   <= d_wr && take;
            x_is_load_o    <= d_load && take;
            x_is_store_o   <= d_store && take;
            x_is_mul_o     <= d_mul && take;
            x_is_div_o     <= d_div && take;
            x_is_illegal_o <= d_ill && take;
        end
    end

endmodule

// File: tb/tb_urv_decode_mc.sv
// Scoreboard bench for urv_decode_mc: two instances, one with default
// parameters and one with 3 load / 2 mul bubbles and full M-extension.
module tb_urv_decode_mc;
    import urv_decode_mc_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
        logic        ld;
        logic        stv;
        logic        mul;
        logic        dv;
        logic [2:0]  src;
        logic [31:0] imm;
        logic        ci;
        logic        bub;
    } exp_t;

    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00228333;
    localparam logic [31:0] LUI5  = 32'h000012B7;
    localparam logic [31:0] LW0   = 32'h0000A003;
    localparam logic [31:0] ADD00 = 32'h00000333;
    localparam logic [31:0] DIV3  = 32'h0220C1B3;
    localparam logic [31:0] MULH4 = 32'h02209233;
    localparam logic [31:0] MUL5  = 32'h021282B3;
    localparam logic [31:0] SLLI8 = 32'h00329413;
    localparam logic [31:0] ADDI9 = 32'h00140493;
    localparam logic [31:0] SW5   = 32'h0050A423;
    localparam logic [31:0] BEQ   = 32'hFE208EE3;
    localparam logic [31:0] JAL1  = 32'h010000EF;
    localparam logic [31:0] CSRW  = 32'h30009573;
    localparam logic [31:0] ILL   = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_stall [2];
    logic        d_kill [2];
    logic        stall_req [2];
    logic [31:0] f_ir [2];
    logic [31:0] f_pc [2];
    logic        f_valid [2];
    logic [4:0]  rf_rs1 [2];
    logic [4:0]  rf_rs2 [2];
    logic        x_valid [2];
    logic [31:0] x_pc [2];
    logic [4:0]  x_rs1 [2];
    logic [4:0]  x_rs2 [2];
    logic [4:0]  x_rd [2];
    logic [4:0]  x_opcode [2];
    logic [2:0]  x_fun [2];
    logic [31:0] x_imm [2];
    logic [2:0]  x_src [2];
    logic        x_wr [2];
    logic        x_ld [2];
    logic        x_st [2];
    logic        x_mul [2];
    logic        x_div [2];
    logic        x_ill [2];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last [2];

    always #5 clk = ~clk;

    urv_decode_mc u_a (
        .clk_i(clk), .rst_i(rst), .d_stall_i(d_stall[0]),
        .d_kill_i(d_kill[0]), .d_stall_req_o(stall_req[0]),
        .f_ir_i(f_ir[0]), .f_pc_i(f_pc[0]), .f_valid_i(f_valid[0]),
        .rf_rs1_o(rf_rs1[0]), .rf_rs2_o(rf_rs2[0]),
        .x_valid_o(x_valid[0]), .x_pc_o(x_pc[0]),
        .x_rs1_o(x_rs1[0]), .x_rs2_o(x_rs2[0]), .x_rd_o(x_rd[0]),
        .x_opcode_o(x_opcode[0]), .x_fun_o(x_fun[0]), .x_imm_o(x_imm[0]),
        .x_rd_source_o(x_src[0]), .x_rd_write_o(x_wr[0]),
        .x_is_load_o(x_ld[0]), .x_is_store_o(x_st[0]),
        .x_is_mul_o(x_mul[0]), .x_is_div_o(x_div[0]),
        .x_is_illegal_o(x_ill[0])
    );

    urv_decode_mc #(
        .g_load_bubbles(3), .g_mul_bubbles(2),
        .g_with_hw_mulh(1'b1), .g_with_hw_div(1'b1)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .d_stall_i(d_stall[1]),
        .d_kill_i(d_kill[1]), .d_stall_req_o(stall_req[1]),
        .f_ir_i(f_ir[1]), .f_pc_i(f_pc[1]), .f_valid_i(f_valid[1]),
        .rf_rs1_o(rf_rs1[1]), .rf_rs2_o(rf_rs2[1]),
        .x_valid_o(x_valid[1]), .x_pc_o(x_pc[1]),
        .x_rs1_o(x_rs1[1]), .x_rs2_o(x_rs2[1]), .x_rd_o(x_rd[1]),
        .x_opcode_o(x_opcode[1]), .x_fun_o(x_fun[1]), .x_imm_o(x_imm[1]),
        .x_rd_source_o(x_src[1]), .x_rd_write_o(x_wr[1]),
        .x_is_load_o(x_ld[1]), .x_is_store_o(x_st[1]),
        .x_is_mul_o(x_mul[1]), .x_is_div_o(x_div[1]),
        .x_is_illegal_o(x_ill[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i, input bit mh,
                                     input bit dv);
        exp_t e;
        logic [2:0] f;
        f = i[14:12];
        e = '0;
        e.valid = 1'b1;
        e.rd = i[11:7];
        e.src = RD_SOURCE_ALU;
        case (i[6:0])
            7'h37, 7'h17: begin
                e.imm = {i[31:12], 12'h0}; e.ci = 1; e.wr = 1;
            end
            7'h6f: begin
                e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
                e.ci = 1; e.wr = 1;
            end
            7'h67: begin
                e.imm = {{20{i[31]}}, i[31:20]}; e.ci = 1; e.wr = 1;
            end
            7'h63: begin
                e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                e.ci = 1;
            end
            7'h03: begin
                e.imm = {{20{i[31]}}, i[31:20]}; e.ci = 1; e.wr = 1;
                e.ld = 1;
            end
            7'h23: begin
                e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.ci = 1;
                e.stv = 1;
            end
            7'h13: begin
                e.wr = 1;
                if (f == 3'd1 || f == 3'd5) e.src = RD_SOURCE_SHIFTER;
            end
            7'h33: begin
                e.wr = 1;
                if (i[31:25] == 7'h01) begin
                    if (f == 3'd0 || (f < 3'd4 && mh)) begin
                        e.mul = 1; e.src = RD_SOURCE_MULTIPLY;
                    end else if (f >= 3'd4 && dv) begin
                        e.dv = 1; e.src = RD_SOURCE_DIVIDE;
                    end else begin
                        e.ill = 1;
                    end
                end else if (f == 3'd1 || f == 3'd5) begin
                    e.src = RD_SOURCE_SHIFTER;
                end
            end
            7'h73: begin
                e.src = RD_SOURCE_CSR; e.wr = (f != 3'd0);
            end
            7'h0f: ;
            default: e.ill = 1;
        endcase
        if (e.ill || e.rd == 5'd0) e.wr = 0;
        return e;
    endfunction

    // One fetch cycle on instance s; ereq/ev are the expected stall
    // request this cycle and whether X holds this instruction next.
    task automatic cyc(input int s, input logic [31:0] ir,
                       input logic [31:0] pc, input logic fv,
                       input logic st, input logic kl,
                       input logic ereq, input logic ev);
        exp_t e;
        logic [4:0] r1, r2;
        @(negedge clk);
        f_ir[s] = ir;
        f_pc[s] = pc;
        f_valid[s] = fv;
        d_stall[s] = st;
        d_kill[s] = kl;
        #1;
        r1 = ir[19:15];
        r2 = ir[24:20];
        chk("stall_req", 32'(stall_req[s]), 32'(ereq));
        chk("rf_rs1", 32'(rf_rs1[s]), 32'(r1));
        chk("rf_rs2", 32'(rf_rs2[s]), 32'(r2));
        if (kl) begin
            e = '0;
        end else if (st) begin
            e = last[s];
        end else if (ev) begin
            e = ref_dec(ir, s == 1, s == 1);
            e.pc = pc;
        end else begin
            e = '0;
            e.bub = 1'b1;
        end
        last[s] = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("x_valid", 32'(x_valid[s]), 32'(e.valid));
        if (e.valid) begin
            chk("x_pc", x_pc[s], e.pc);
            chk("x_rd", 32'(x_rd[s]), 32'(e.rd));
            chk("x_rd_write", 32'(x_wr[s]), 32'(e.wr));
            chk("x_is_illegal", 32'(x_ill[s]), 32'(e.ill));
            chk("x_is_load", 32'(x_ld[s]), 32'(e.ld));
            chk("x_is_store", 32'(x_st[s]), 32'(e.stv));
            chk("x_is_mul", 32'(x_mul[s]), 32'(e.mul));
            chk("x_is_div", 32'(x_div[s]), 32'(e.dv));
            chk("x_rd_source", 32'(x_src[s]), 32'(e.src));
            if (e.ci) chk("x_imm", x_imm[s], e.imm);
        end else if (e.bub) begin
            chk("bub_load", 32'(x_ld[s]), 32'd0);
            chk("bub_store", 32'(x_st[s]), 32'd0);
            chk("bub_write", 32'(x_wr[s]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            d_stall[s] = 0; d_kill[s] = 0; f_valid[s] = 0;
            f_ir[s] = '0; f_pc[s] = '0; last[s] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_valid", 32'(x_valid[s]), 32'd0);
            chk("rst_pc", x_pc[s], 32'd0);
            chk("rst_flags", 32'({x_ld[s], x_st[s], x_mul[s], x_div[s],
                                  x_wr[s], x_ill[s]}), 32'd0);
            chk("rst_req", 32'(stall_req[s]), 32'd0);
        end
        rst = 1'b0;

        // Instance A: one bubble per hazard, M-extension minimal
        cyc(0, LW5,   32'h100, 1, 0, 0, 0, 1);
        cyc(0, ADD6,  32'h104, 1, 0, 0, 1, 0);
        cyc(0, ADD6,  32'h104, 1, 0, 0, 0, 1);
        cyc(0, LW5,   32'h108, 1, 0, 0, 0, 1);
        cyc(0, LUI5,  32'h10c, 1, 0, 0, 0, 1);
        cyc(0, LW0,   32'h110, 1, 0, 0, 0, 1);
        cyc(0, ADD00, 32'h114, 1, 0, 0, 0, 1);
        cyc(0, DIV3,  32'h118, 1, 0, 0, 0, 1);
        cyc(0, MULH4, 32'h11c, 1, 0, 0, 0, 1);
        cyc(0, SLLI8, 32'h120, 1, 0, 0, 0, 1);
        cyc(0, ADDI9, 32'h124, 1, 0, 0, 1, 0);
        cyc(0, ADDI9, 32'h124, 1, 0, 0, 0, 1);
        cyc(0, SW5,   32'h128, 1, 0, 0, 0, 1);
        cyc(0, BEQ,   32'h12c, 1, 0, 0, 0, 1);
        cyc(0, JAL1,  32'h130, 1, 0, 0, 0, 1);
        cyc(0, CSRW,  32'h134, 1, 0, 0, 0, 1);
        cyc(0, ILL,   32'h138, 1, 0, 0, 0, 1);
        cyc(0, LW5,   32'h13c, 1, 0, 0, 0, 1);
        cyc(0, ADD6,  32'h140, 1, 1, 1, 0, 0);
        cyc(0, ADD6,  32'h140, 1, 0, 0, 0, 1);
        cyc(0, ADD6,  32'h144, 0, 0, 0, 0, 0);

        // Instance B: 3 load bubbles, 2 mul bubbles, full M-extension
        cyc(1, LW5,   32'h200, 1, 0, 0, 0, 1);
        repeat (3) cyc(1, ADD6, 32'h204, 1, 0, 0, 1, 0);
        cyc(1, ADD6,  32'h204, 1, 0, 0, 0, 1);
        cyc(1, LW5,   32'h208, 1, 0, 0, 0, 1);
        cyc(1, ADD6,  32'h20c, 1, 0, 0, 1, 0);
        cyc(1, ADD6,  32'h20c, 1, 0, 1, 0, 0);
        cyc(1, ADD6,  32'h20c, 1, 0, 0, 0, 1);
        cyc(1, LW5,   32'h210, 1, 0, 0, 0, 1);
        cyc(1, ADD6,  32'h214, 1, 0, 0, 1, 0);
        repeat (2) cyc(1, ADD6, 32'h214, 1, 1, 0, 1, 0);
        repeat (2) cyc(1, ADD6, 32'h214, 1, 0, 0, 1, 0);
        cyc(1, ADD6,  32'h214, 1, 0, 0, 0, 1);
        cyc(1, DIV3,  32'h218, 1, 0, 0, 0, 1);
        cyc(1, MULH4, 32'h21c, 1, 0, 0, 0, 1);
        cyc(1, MUL5,  32'h220, 1, 0, 0, 0, 1);
        repeat (2) cyc(1, ADD6, 32'h224, 1, 0, 0, 1, 0);
        cyc(1, ADD6,  32'h224, 1, 0, 0, 0, 1);
        cyc(1, LW5,   32'h230, 1, 0, 0, 0, 1);
        cyc(1, ADD6,  32'h234, 1, 0, 0, 1, 0);

        // Reset in the middle of a bubble sequence
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", 32'(stall_req[1]), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 32'(x_valid[1]), 32'd0);
        chk("rst_mid_pc", x_pc[1], 32'd0);
        chk("rst_mid_load", 32'(x_ld[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last[1] = '0;
        cyc(1, ADD6,  32'h234, 1, 0, 0, 0, 1);
        cyc(1, ADD6,  32'h238, 0, 0, 0, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
